// File: rtl/jtframe_obj_line_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtframe_obj_line_if : table, ROM and line-buffer ports of the sprite renderer
// Rev 1.0
// ----------------------------------------------------------------------------
interface jtframe_obj_line_if #(
  parameter int OBJS = 32,
  parameter int CW   = 12
);
  localparam int c_aw = $clog2(OBJS) + 3;

  logic [c_aw-1:0] scan_addr;
  logic [7:0]      scan_dout;
  logic [CW+4:0]   rom_addr;
  logic            rom_cs;
  logic            rom_ok;
  logic [31:0]     rom_data;
  logic [8:0]      buf_addr;
  logic [7:0]      buf_data;
  logic            buf_we;

  modport master (
    output scan_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    input  scan_dout, rom_ok, rom_data
  );

  modport slave (
    input  scan_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    output scan_dout, rom_ok, rom_data
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_obj_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtframe_obj_line : scans the object table and draws matching sprites' rows
// Rev 1.0
// ----------------------------------------------------------------------------
module jtframe_obj_line #(
  parameter int OBJS    = 32,
  parameter int CW      = 12,
  parameter int MAXLINE = 16,
  parameter int TRANSP  = 1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       LHBL,
  input  logic       flip,
  input  logic [8:0] v,
  output logic       ovf,
  output logic       busy,
  jtframe_obj_line_if.master bus
);
  localparam int c_ow = $clog2(OBJS);
  localparam int c_nw = $clog2(OBJS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_FETCH = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_lhbl;
  logic [c_ow-1:0] r_obj;
  logic [2:0]      r_byte, r_k;
  logic [1:0]      r_grp;
  logic [c_nw-1:0] r_cnt;
  logic            r_fwait, r_ovf;
  logic [6:0]      r_row;
  logic [31:0]     r_data;
  logic [7:0]      r_ent [0:7];

  logic            w_start, w_wide, w_hflip, w_vflip, w_match;
  logic            w_obj_last, w_grp_last, w_full;
  logic [1:0]      w_vsize, w_gmax, w_s;
  logic [3:0]      w_pal, w_pix, w_step;
  logic [2:0]      w_pk;
  logic [8:0]      w_y, w_x, w_vf, w_row;
  logic [18:0]     w_code_full;
  logic [CW-1:0]   w_code, w_tile;
  logic            w_unused;

  // LHBL rise is taken from two registered samples to stay glitch free
  assign w_start     = r_lhbl[0] & ~r_lhbl[1];

  assign w_pal       = r_ent[0][3:0];
  assign w_wide      = r_ent[1][0];
  assign w_y         = {r_ent[3][0], r_ent[2]};
  assign w_vflip     = r_ent[5][7];
  assign w_hflip     = r_ent[5][6];
  assign w_vsize     = r_ent[5][5:4];
  assign w_x         = {r_ent[7][0], r_ent[6]};
  assign w_code_full = {r_ent[1][7:1], r_ent[5][3:0], r_ent[4]};
  assign w_code      = w_code_full[CW-1:0];
  assign w_unused    = ^{r_ent[0][7:4], r_ent[3][7:1], r_ent[7][7:1], w_code_full};

  assign w_vf        = v ^ {9{flip}};
  assign w_row       = w_vf - w_y;
  assign w_match     = {1'b0, w_row} < (10'd16 << w_vsize);

  assign w_gmax      = w_wide ? 2'd3 : 2'd1;
  assign w_s         = w_hflip ? (w_gmax - r_grp) : r_grp;
  assign w_step      = w_wide ? {r_row[6:4], 1'b0} : {1'b0, r_row[6:4]};
  assign w_tile      = w_code + CW'(w_step) + CW'(w_s[1]);

  // pixel k of a ROM word sits in nibble k
  assign w_pk        = w_hflip ? ~r_k : r_k;
  assign w_pix       = r_data[{w_pk, 2'b00} +: 4];

  assign w_obj_last  = r_obj == c_ow'(OBJS - 1);
  assign w_grp_last  = r_grp == w_gmax;
  assign w_full      = r_cnt == c_nw'(MAXLINE);

  assign bus.scan_addr = {r_obj, r_byte};
  assign bus.rom_addr  = {w_tile, r_row[3:0] ^ {4{w_vflip}}, w_s[0]};
  assign bus.rom_cs    = (r_state == S_FETCH) && !w_start;
  assign bus.buf_addr  = w_x + 9'({r_grp, r_k});
  assign bus.buf_data  = {w_pal, w_pix};
  assign bus.buf_we    = (r_state == S_WRITE) && !w_start && ((TRANSP == 0) || (w_pix != 4'd0));
  assign ovf           = r_ovf;
  assign busy          = r_state != S_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_READ:  if (r_byte == 3'd7) w_next = S_CHECK;
      S_CHECK: begin
        if (w_match)         w_next = S_FETCH;
        else if (w_obj_last) w_next = S_DONE;
        else                 w_next = S_READ;
      end
      S_FETCH: if (r_fwait && bus.rom_ok) w_next = S_WRITE;
      S_WRITE: begin
        if (r_k == 3'd7) begin
          if (!w_grp_last)               w_next = S_FETCH;
          else if (w_full || w_obj_last) w_next = S_DONE;
          else                           w_next = S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_start) w_next = S_READ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lhbl  <= 2'b11;
      r_obj   <= '0;
      r_byte  <= '0;
      r_k     <= '0;
      r_grp   <= '0;
      r_cnt   <= '0;
      r_fwait <= 1'b0;
      r_ovf   <= 1'b0;
      r_row   <= '0;
      r_data  <= '0;
      for (int i = 0; i < 8; i++) r_ent[i] <= '0;
    end else begin
      r_state <= w_next;
      r_lhbl  <= {r_lhbl[0], LHBL};
      if (w_start) begin
        r_obj   <= '0;
        r_byte  <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_fwait <= 1'b0;
      end else begin
        case (r_state)
          S_READ: begin
            r_byte <= r_byte + 3'd1;
            // table RAM answers one cycle after the address
            if (r_byte != 3'd0) r_ent[r_byte - 3'd1] <= bus.scan_dout;
          end
          S_CHECK: begin
            r_ent[7] <= bus.scan_dout;
            r_row    <= w_row[6:0];
            r_grp    <= '0;
            r_fwait  <= 1'b0;
            if (w_match) r_cnt <= r_cnt + 1'b1;
            else         r_obj <= r_obj + 1'b1;
          end
          S_FETCH: begin
            // the first FETCH cycle never accepts rom_ok
            r_fwait <= 1'b1;
            r_k     <= '0;
            if (r_fwait && bus.rom_ok) r_data <= bus.rom_data;
          end
          S_WRITE: begin
            r_k <= r_k + 3'd1;
            if (r_k == 3'd7) begin
              r_fwait <= 1'b0;
              if (!w_grp_last) begin
                r_grp <= r_grp + 2'd1;
              end else begin
                r_obj <= r_obj + 1'b1;
                if (w_full) r_ovf <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_jtframe_obj_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jtframe_obj_line : directed and random lines against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_jtframe_obj_line;
  localparam int OBJS = 32, CW = 12, MAXLINE = 16, TRANSP = 1;

  logic       clk = 1'b0;
  logic       rst, LHBL, flip;
  logic [8:0] v;
  logic       ovf, busy;

  jtframe_obj_line_if #(.OBJS(OBJS), .CW(CW)) bus();

  jtframe_obj_line #(.OBJS(OBJS), .CW(CW), .MAXLINE(MAXLINE), .TRANSP(TRANSP)) dut (
    .clk  (clk),
    .rst  (rst),
    .LHBL (LHBL),
    .flip (flip),
    .v    (v),
    .ovf  (ovf),
    .busy (busy),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;
  logic [7:0] tbl [0:OBJS*8-1];
  bit  pattern_mode = 1'b1, stall = 1'b0;

  function automatic logic [31:0] rom_word(input int a);
    if (pattern_mode) return 32'h76543210;
    return (a * 32'h9E3779B1) ^ (a << 7) ^ 32'h13572468;
  endfunction

  // synchronous table RAM
  always @(posedge clk) bus.scan_dout <= tbl[bus.scan_addr];

  // ROM with random latency; junk rom_ok while not selected
  int            rom_wait = 0;
  bit            rom_act  = 1'b0;
  logic [CW+4:0] rom_cur  = '0;
  always @(posedge clk) begin
    if (bus.rom_cs) begin
      if (!rom_act || bus.rom_addr != rom_cur) begin
        rom_act    <= 1'b1;
        rom_cur    <= bus.rom_addr;
        rom_wait   <= int'($urandom_range(0, 3));
        bus.rom_ok <= 1'b0;
      end else if (stall) begin
        bus.rom_ok <= 1'b0;
      end else if (rom_wait == 0) begin
        bus.rom_ok   <= 1'b1;
        bus.rom_data <= rom_word(int'(bus.rom_addr));
      end else begin
        rom_wait <= rom_wait - 1;
      end
    end else begin
      rom_act      <= 1'b0;
      bus.rom_ok   <= 1'($urandom_range(0, 1));
      bus.rom_data <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int            cap [512];
  int            nwr = 0;
  logic [CW+4:0] fetch_log [$];
  logic          prev_cs = 1'b0;
  logic [CW+4:0] prev_addr = '0;
  always @(negedge clk) begin
    if (bus.buf_we === 1'b1) begin
      cap[bus.buf_addr] = int'(bus.buf_data);
      nwr++;
    end
    if (bus.rom_cs === 1'b1 && !prev_cs) fetch_log.push_back(bus.rom_addr);
    if (bus.rom_cs === 1'b1 && prev_cs) check("rom_addr_stable", 32'(bus.rom_addr), 32'(prev_addr));
    prev_cs   = (bus.rom_cs === 1'b1);
    prev_addr = bus.rom_addr;
  end

  int exp_line [512];
  int exp_nwr;
  bit exp_ovf;

  task automatic model_line();
    int cnt, y, x, vs, hf, vfl, wide, code, vf, row, g_n, s, tile, a, pix, p, pal;
    logic [31:0] d;
    cnt = 0; exp_ovf = 0; exp_nwr = 0;
    foreach (exp_line[i]) exp_line[i] = -1;
    vf = flip ? 511 - int'(v) : int'(v);
    for (int o = 0; o < OBJS; o++) begin
      pal  = int'(tbl[o*8+0]) % 16;
      wide = int'(tbl[o*8+1]) % 2;
      y    = int'(tbl[o*8+2]) + 256 * (int'(tbl[o*8+3]) % 2);
      code = (int'(tbl[o*8+4]) + 256 * (int'(tbl[o*8+5]) % 16)
              + 4096 * (int'(tbl[o*8+1]) / 2)) % (1 << CW);
      vs   = (int'(tbl[o*8+5]) / 16) % 4;
      hf   = (int'(tbl[o*8+5]) / 64) % 2;
      vfl  = int'(tbl[o*8+5]) / 128;
      x    = int'(tbl[o*8+6]) + 256 * (int'(tbl[o*8+7]) % 2);
      row  = (vf - y + 512) % 512;
      if (row < (16 << vs)) begin
        cnt++;
        g_n = wide ? 4 : 2;
        for (int g = 0; g < g_n; g++) begin
          s    = hf ? g_n - 1 - g : g;
          tile = (code + (row / 16) * (wide ? 2 : 1) + s / 2) % (1 << CW);
          a    = tile * 32 + (vfl ? 15 - row % 16 : row % 16) * 2 + s % 2;
          d    = rom_word(a);
          for (int k = 0; k < 8; k++) begin
            p   = hf ? 7 - k : k;
            pix = int'((d >> (4 * p)) & 32'hF);
            if (!(TRANSP != 0 && pix == 0)) begin
              exp_line[(x + 8 * g + k) % 512] = pal * 16 + pix;
              exp_nwr++;
            end
          end
        end
        if (cnt == MAXLINE) begin
          exp_ovf = 1;
          break;
        end
      end
    end
  endtask

  task automatic set_obj(input int o, input int pal, input int wide, input int y, input int code,
                         input int vfl, input int hfl, input int vs, input int x);
    tbl[o*8+0] = 8'(pal);
    tbl[o*8+1] = 8'(wide | ((code >> 12) << 1));
    tbl[o*8+2] = 8'(y);
    tbl[o*8+3] = 8'((y >> 8) & 1);
    tbl[o*8+4] = 8'(code);
    tbl[o*8+5] = 8'((vfl << 7) | (hfl << 6) | (vs << 4) | ((code >> 8) & 15));
    tbl[o*8+6] = 8'(x);
    tbl[o*8+7] = 8'((x >> 8) & 1);
  endtask

  task automatic clear_tbl();
    int vf;
    vf = flip ? 511 - int'(v) : int'(v);
    for (int o = 0; o < OBJS; o++) set_obj(o, 0, 0, (vf + 200) % 512, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_cap();
    foreach (cap[i]) cap[i] = -1;
    nwr = 0;
    fetch_log.delete();
  endtask

  task automatic start_line();
    int n;
    @(negedge clk) LHBL = 1'b0;
    repeat (3) @(negedge clk);
    clear_cap();
    LHBL = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("busy_start", 32'(busy), 32'd1);
    check("ovf_cleared", 32'(ovf), 32'd0);
  endtask

  task automatic finish_line(input string tag);
    int n, nbad;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(busy), 32'd0);
    model_line();
    nbad = 0;
    foreach (cap[i]) if (cap[i] != exp_line[i]) nbad++;
    check({tag, "_line_diffs"}, 32'(nbad), 32'd0);
    check({tag, "_writes"}, 32'(nwr), 32'(exp_nwr));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic run_line(input string tag);
    start_line();
    finish_line(tag);
  endtask

  initial begin
    int vf, n;
    rst = 1'b1; LHBL = 1'b1; flip = 1'b0; v = 9'd100;
    for (int i = 0; i < OBJS * 8; i++) tbl[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_scan_addr", 32'(bus.scan_addr), 32'd0);
    check("rst_rom_cs",    32'(bus.rom_cs),    32'd0);
    check("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
    check("rst_buf_we",    32'(bus.buf_we),    32'd0);
    check("rst_buf_addr",  32'(bus.buf_addr),  32'd0);
    check("rst_buf_data",  32'(bus.buf_data),  32'd0);
    check("rst_ovf",       32'(ovf),           32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single 16-wide object, transparent pen 0
    clear_tbl();
    set_obj(0, 5, 0, 100, 12'h010, 0, 0, 0, 20);
    run_line("basic");
    check("basic_x20",   32'(cap[20]), 32'hFFFFFFFF);
    check("basic_x21",   32'(cap[21]), 32'h51);
    check("basic_x35",   32'(cap[35]), 32'h57);
    check("basic_nwr",   32'(nwr), 32'd14);
    check("basic_fetch0", 32'(fetch_log[0]), 32'h200);
    check("basic_fetch1", 32'(fetch_log[1]), 32'h201);

    // wide and horizontally flipped
    set_obj(0, 5, 1, 100, 12'h010, 0, 1, 0, 20);
    run_line("hflip_wide");
    check("hw_fetch0", 32'(fetch_log[0]), 32'h221);
    check("hw_fetch1", 32'(fetch_log[1]), 32'h220);
    check("hw_x20",    32'(cap[20]), 32'h57);
    check("hw_x27",    32'(cap[27]), 32'hFFFFFFFF);
    check("hw_nwr",    32'(nwr), 32'd28);

    // tall object, row 100
    v = 9'd200;
    clear_tbl();
    set_obj(0, 5, 0, 100, 12'h010, 0, 0, 3, 20);
    run_line("tall");
    check("tall_fetch0", 32'(fetch_log[0]), 32'h2C8);
    set_obj(0, 5, 0, 100, 12'h010, 1, 0, 3, 20);
    run_line("tall_vflip");
    check("tallv_fetch0", 32'(fetch_log[0]), 32'h2D6);

    // 20 objects on the line, only MAXLINE drawn
    pattern_mode = 1'b0;
    v = 9'd100;
    clear_tbl();
    for (int o = 0; o < 20; o++) set_obj(o, o, 0, 100 - o, 12'h100 + o, 0, 0, 0, 16 * o);
    run_line("limit");
    check("limit_ovf",     32'(ovf), 32'd1);
    check("limit_fetches", 32'(fetch_log.size()), 32'd32);
    clear_tbl();
    set_obj(7, 2, 0, 95, 12'h033, 0, 0, 0, 40);
    run_line("after_limit");

    // horizontal wrap at the right edge
    pattern_mode = 1'b1;
    clear_tbl();
    set_obj(0, 5, 0, 100, 12'h010, 0, 0, 0, 508);
    run_line("xwrap");
    check("xwrap_x508", 32'(cap[508]), 32'hFFFFFFFF);
    check("xwrap_x511", 32'(cap[511]), 32'h53);
    check("xwrap_x0",   32'(cap[0]),   32'h54);

    // ROM stalls, then a new line start aborts the scan
    pattern_mode = 1'b0;
    clear_tbl();
    set_obj(3, 9, 1, 90, 12'h0A5, 0, 1, 1, 300);
    set_obj(5, 4, 0, 99, 12'h0B0, 1, 0, 0, 310);
    stall = 1'b1;
    start_line();
    n = 0;
    while (bus.rom_cs !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    check("stall_cs_held", 32'(bus.rom_cs), 32'd1);
    check("stall_no_write", 32'(nwr), 32'd0);
    LHBL = 1'b0;
    repeat (3) @(negedge clk);
    clear_cap();
    LHBL  = 1'b1;
    stall = 1'b0;
    n = 0;
    while (bus.rom_cs === 1'b1 && n < 5) begin @(negedge clk); n++; end
    check("abort_cs_low", 32'(bus.rom_cs), 32'd0);
    @(negedge clk);
    check("abort_scan0", 32'(bus.scan_addr), 32'd0);
    finish_line("abort");

    // random tables, lines and flip
    for (int t = 0; t < 8; t++) begin
      v    = 9'($urandom_range(0, 511));
      flip = 1'($urandom_range(0, 1));
      vf   = flip ? 511 - int'(v) : int'(v);
      for (int o = 0; o < OBJS; o++) begin
        int y;
        for (int j = 0; j < 8; j++) tbl[o*8+j] = 8'($urandom);
        if ($urandom_range(0, 99) < 60) y = (vf - int'($urandom_range(0, 140)) + 512) % 512;
        else                            y = int'($urandom_range(0, 511));
        tbl[o*8+2] = 8'(y);
        tbl[o*8+3] = {tbl[o*8+3][7:1], 1'(y >> 8)};
      end
      run_line("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
`default_nettype wire
